// File: rtl/cory_packn.sv
// cory_packn: N-channel valid/ready packer; one holding slot per channel, masked
// channels are skipped, and a full set is concatenated into a registered output beat.
module cory_packn #(
  parameter int NCH = 8,
  parameter int W   = 8,
  parameter int Z   = NCH * W
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [NCH-1:0] i_a_v,
  input  logic [Z-1:0]   i_a_d,
  output logic [NCH-1:0] o_a_r,
  input  logic [NCH-1:0] i_mask,
  output logic           o_z_v,
  output logic [Z-1:0]   o_z_d,
  input  logic           i_z_r,
  output logic           o_idle
);
  logic [NCH-1:0]        h_v_q, h_v_d;
  logic [NCH-1:0][W-1:0] h_d_q, h_d_d;
  logic                  z_v_q, z_v_d;
  logic [Z-1:0]          z_d_q, z_d_d;
  logic                  out_free, all_in, fire;
  logic [NCH-1:0]        acc;
  assign out_free = ~z_v_q | i_z_r;
  assign all_in   = (&(h_v_q | ~i_mask)) & (|i_mask);
  assign fire     = out_free & all_in;
  // i_z_r reaches ready through fire, so a full slot can refill while it drains
  assign o_a_r    = i_mask & (~h_v_q | {NCH{fire}});
  assign acc      = i_a_v & o_a_r;
  assign o_z_v    = z_v_q;
  assign o_z_d    = z_d_q;
  assign o_idle   = ~(|h_v_q) & ~z_v_q;
  always_comb begin
    h_v_d = (h_v_q & ~({NCH{fire}} & i_mask)) | acc;
    h_d_d = h_d_q;
    z_v_d = fire | (z_v_q & ~i_z_r);
    z_d_d = z_d_q;
    for (int k = 0; k < NCH; k++) begin
      if (acc[k]) h_d_d[k] = i_a_d[k*W +: W];
      if (fire) z_d_d[k*W +: W] = i_mask[k] ? h_d_q[k] : '0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_v_q <= '0;
      h_d_q <= '0;
      z_v_q <= 1'b0;
      z_d_q <= '0;
    end else begin
      h_v_q <= h_v_d;
      h_d_q <= h_d_d;
      z_v_q <= z_v_d;
      z_d_q <= z_d_d;
    end
  end
`ifndef SYNTHESIS
  a_mask_static: assert property (@(posedge clk) disable iff (!reset_n) !$stable(i_mask) |-> o_idle)
    else $error("cory_packn: i_mask changed while not idle");
`endif
`ifdef SIM
`ifdef CORY_MON
  cory_monitor #(.W(Z)) u_mon (
    .clk    (clk),
    .reset_n(reset_n),
    .v      (o_z_v),
    .r      (i_z_r),
    .d      (o_z_d)
  );
`endif
`endif
endmodule
